// File: rtl/sram_rec_pkg.sv
// rtl/sram_rec_pkg.sv - shared types and sizing helpers for the SRAM record store
package sram_rec_pkg;

    typedef enum logic [2:0] {
        IDLE,
        W_SETUP,
        W_PULSE,
        W_HOLD,
        R_SETUP,
        R_WAIT,
        R_DONE
    } state_t;

    // Record-level sequencer: which kind of multi-word transfer is running.
    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_WRITE,
        SEQ_READ,
        SEQ_R_DONE
    } seq_t;

    function automatic int wpr(input int data_w, input int sram_dw);
        return data_w / sram_dw;
    endfunction

    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sram_word_port.sv
// rtl/sram_word_port.sv - one SRAM word access with WAIT_CYC strobe timing
module sram_word_port
    import sram_rec_pkg::*;
#(
    parameter int SRAM_DW  = 16,
    parameter int ADDR_W   = 19,
    parameter int WAIT_CYC = 2
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic               we,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [SRAM_DW-1:0] wdata,
    output logic               word_done,
    output logic [SRAM_DW-1:0] rd_word,
    output logic [ADDR_W-1:0]  sram_addr,
    inout  wire  [SRAM_DW-1:0] sram_data,
    output logic               sram_we_n,
    output logic               sram_oe_n,
    output logic               sram_ce_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);

    localparam int CW = $clog2(WAIT_CYC + 1);

    state_t             state, state_nx;
    logic [CW-1:0]      cnt, cnt_nx;
    logic [SRAM_DW-1:0] wdata_q;
    logic               load;
    logic               last_wait;

    assign last_wait = (cnt == CW'(WAIT_CYC - 1));

    // A start seen on word_done chains straight into the next setup cycle.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        word_done = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE:    load = start;
            W_SETUP: begin
                state_nx = W_PULSE;
                cnt_nx   = '0;
            end
            W_PULSE: begin
                if (last_wait) state_nx = W_HOLD;
                else           cnt_nx   = cnt + 1'b1;
            end
            W_HOLD: begin
                word_done = 1'b1;
                load      = start;
                if (!start) state_nx = IDLE;
            end
            R_SETUP: begin
                state_nx = R_WAIT;
                cnt_nx   = '0;
            end
            R_WAIT: begin
                if (last_wait) begin
                    word_done = 1'b1;
                    load      = start;
                    if (!start) state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (load) state_nx = we ? W_SETUP : R_SETUP;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= IDLE;
            cnt       <= '0;
            sram_addr <= '0;
            wdata_q   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (load) begin
                sram_addr <= addr;
                wdata_q   <= wdata;
            end
        end
    end

    logic active, drive;
    assign active    = (state != IDLE) && (state != R_DONE);
    assign drive     = (state == W_SETUP) || (state == W_PULSE) || (state == W_HOLD);
    assign sram_ce_n = !active;
    assign sram_ub_n = !active;
    assign sram_lb_n = !active;
    assign sram_we_n = (state != W_PULSE);
    assign sram_oe_n = !((state == R_SETUP) || (state == R_WAIT));
    assign sram_data = drive ? wdata_q : {SRAM_DW{1'bz}};
    assign rd_word   = sram_data;

endmodule

// File: rtl/sram_rec_store.sv
// rtl/sram_rec_store.sv - DEPTH-record store over async SRAM with wrap and range checks
module sram_rec_store
    import sram_rec_pkg::*;
#(
    parameter int  DATA_W    = 32,
    parameter int  SRAM_DW   = 16,
    parameter int  ADDR_W    = 19,
    parameter int  DEPTH     = 8,
    parameter int  BASE_ADDR = 0,
    parameter int  WAIT_CYC  = 2,
    parameter int  WRAP      = 1,
    localparam int IW        = idx_w(DEPTH),
    localparam int WPR       = wpr(DATA_W, SRAM_DW),
    localparam int WIW       = (WPR > 1) ? idx_w(WPR) : 1
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               wr_req,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic               rd_req,
    input  logic [IW-1:0]      rd_idx,
    output logic [DATA_W-1:0]  rd_data,
    output logic               rd_vld,
    output logic               busy,
    output logic [IW:0]        rec_cnt,
    output logic               full,
    output logic               err,
    output logic [ADDR_W-1:0]  sram_addr,
    inout  wire  [SRAM_DW-1:0] sram_data,
    output logic               sram_we_n,
    output logic               sram_oe_n,
    output logic               sram_ce_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);

    seq_t               seq, seq_nx;
    logic [IW-1:0]      wr_ptr, pend_idx, ptr_inc;
    logic [IW:0]        cnt_inc;
    logic [WIW-1:0]     word_idx;
    logic [DATA_W-1:0]  wr_buf, rd_shift, shift_nx;
    logic               pend_rd, err_nx;
    logic               start, start_we, word_done, last_word;
    logic               wr_ok, rd_ok_now, pend_ok;
    logic [ADDR_W-1:0]  start_addr;
    logic [SRAM_DW-1:0] start_wdata, rd_word;

    function automatic logic [ADDR_W-1:0] rec_addr(input logic [IW-1:0] idx);
        return ADDR_W'(BASE_ADDR) + ADDR_W'(idx) * ADDR_W'(WPR);
    endfunction

    // Once wrapped, indices count from the oldest record, which sits at wr_ptr.
    function automatic logic [IW-1:0] phys(input logic [IW-1:0] idx,
                                           input logic [IW-1:0] ptr,
                                           input logic          is_full);
        return (WRAP != 0 && is_full) ? idx + ptr : idx;
    endfunction

    assign full      = (rec_cnt == (IW+1)'(DEPTH));
    assign cnt_inc   = full ? rec_cnt : rec_cnt + 1'b1;
    assign ptr_inc   = wr_ptr + 1'b1;
    assign wr_ok     = wr_req && !(full && WRAP == 0);
    assign rd_ok_now = ({1'b0, rd_idx} < rec_cnt);
    assign pend_ok   = ({1'b0, pend_idx} < cnt_inc);
    assign last_word = (word_idx == WIW'(WPR - 1));
    assign shift_nx  = (rd_shift << SRAM_DW) | DATA_W'(rd_word);
    assign rd_vld    = (seq == SEQ_R_DONE);
    assign busy      = (seq != SEQ_IDLE);

    always_comb begin
        seq_nx      = seq;
        start       = 1'b0;
        start_we    = 1'b0;
        start_addr  = sram_addr + 1'b1;
        start_wdata = wr_buf[DATA_W-1 -: SRAM_DW];
        err_nx      = 1'b0;
        case (seq)
            SEQ_IDLE: begin
                err_nx = (wr_req && !wr_ok) || (rd_req && !wr_ok && !rd_ok_now);
                if (wr_ok) begin
                    start       = 1'b1;
                    start_we    = 1'b1;
                    start_addr  = rec_addr(wr_ptr);
                    start_wdata = wr_data[DATA_W-1 -: SRAM_DW];
                    seq_nx      = SEQ_WRITE;
                end else if (rd_req && rd_ok_now) begin
                    start      = 1'b1;
                    start_addr = rec_addr(phys(rd_idx, wr_ptr, full));
                    seq_nx     = SEQ_READ;
                end
            end
            SEQ_WRITE: begin
                if (word_done) begin
                    if (!last_word) begin
                        start    = 1'b1;
                        start_we = 1'b1;
                    end else if (pend_rd && pend_ok) begin
                        // Pending read judged against the post-write count and pointer.
                        start      = 1'b1;
                        start_addr = rec_addr(phys(pend_idx, ptr_inc,
                                                   cnt_inc == (IW+1)'(DEPTH)));
                        seq_nx     = SEQ_READ;
                    end else begin
                        err_nx = pend_rd;
                        seq_nx = SEQ_IDLE;
                    end
                end
            end
            SEQ_READ: begin
                if (word_done) begin
                    if (!last_word) start  = 1'b1;
                    else            seq_nx = SEQ_R_DONE;
                end
            end
            default: seq_nx = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            seq      <= SEQ_IDLE;
            wr_ptr   <= '0;
            rec_cnt  <= '0;
            word_idx <= '0;
            wr_buf   <= '0;
            rd_shift <= '0;
            pend_rd  <= 1'b0;
            pend_idx <= '0;
            err      <= 1'b0;
            rd_data  <= '0;
        end else begin
            seq <= seq_nx;
            err <= err_nx;
            if (seq == SEQ_IDLE) begin
                word_idx <= '0;
                wr_buf   <= wr_data << SRAM_DW;
                pend_rd  <= wr_ok && rd_req;
                pend_idx <= rd_idx;
            end
            if (word_done) begin
                word_idx <= last_word ? '0 : word_idx + 1'b1;
                if (seq == SEQ_WRITE) begin
                    wr_buf <= wr_buf << SRAM_DW;
                    if (last_word) begin
                        wr_ptr  <= ptr_inc;
                        rec_cnt <= cnt_inc;
                        pend_rd <= 1'b0;
                    end
                end else begin
                    rd_shift <= shift_nx;
                    if (last_word) rd_data <= shift_nx;
                end
            end
        end
    end

    sram_word_port #(
        .SRAM_DW  (SRAM_DW),
        .ADDR_W   (ADDR_W),
        .WAIT_CYC (WAIT_CYC)
    ) u_port (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .we        (start_we),
        .addr      (start_addr),
        .wdata     (start_wdata),
        .word_done (word_done),
        .rd_word   (rd_word),
        .sram_addr (sram_addr),
        .sram_data (sram_data),
        .sram_we_n (sram_we_n),
        .sram_oe_n (sram_oe_n),
        .sram_ce_n (sram_ce_n),
        .sram_ub_n (sram_ub_n),
        .sram_lb_n (sram_lb_n)
    );

endmodule

// File: tb/tb_sram_rec_store.sv
// tb/tb_sram_rec_store.sv - randomized bench for sram_rec_store against a record-queue model
module tb_sram_rec_store;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        clr, wr_req, rd_req, sel;
    logic [31:0] wr_data;
    logic [2:0]  rd_idx;

    always #5 clk = ~clk;

    // Instance a wraps when full, instance b rejects writes when full.
    logic [31:0] rd_data_a, rd_data_b;
    logic        rd_vld_a, rd_vld_b, busy_a, busy_b, full_a, full_b, err_a, err_b;
    logic [3:0]  rec_cnt_a, rec_cnt_b;
    logic [18:0] addr_a, addr_b;
    wire  [15:0] bus_a, bus_b;
    logic        we_a, oe_a, ce_a, ub_a, lb_a, we_b, oe_b, ce_b, ub_b, lb_b;
    logic [15:0] mem_a [0:63];
    logic [15:0] mem_b [0:63];

    sram_rec_store #(.WRAP(1)) dut_a (
        .clk(clk), .clr(clr), .wr_req(wr_req & ~sel), .wr_data(wr_data),
        .rd_req(rd_req & ~sel), .rd_idx(rd_idx), .rd_data(rd_data_a), .rd_vld(rd_vld_a),
        .busy(busy_a), .rec_cnt(rec_cnt_a), .full(full_a), .err(err_a),
        .sram_addr(addr_a), .sram_data(bus_a), .sram_we_n(we_a), .sram_oe_n(oe_a),
        .sram_ce_n(ce_a), .sram_ub_n(ub_a), .sram_lb_n(lb_a));

    sram_rec_store #(.WRAP(0)) dut_b (
        .clk(clk), .clr(clr), .wr_req(wr_req & sel), .wr_data(wr_data),
        .rd_req(rd_req & sel), .rd_idx(rd_idx), .rd_data(rd_data_b), .rd_vld(rd_vld_b),
        .busy(busy_b), .rec_cnt(rec_cnt_b), .full(full_b), .err(err_b),
        .sram_addr(addr_b), .sram_data(bus_b), .sram_we_n(we_b), .sram_oe_n(oe_b),
        .sram_ce_n(ce_b), .sram_ub_n(ub_b), .sram_lb_n(lb_b));

    always @(posedge clk) if (!ce_a && !we_a) mem_a[addr_a[5:0]] <= bus_a;
    always @(posedge clk) if (!ce_b && !we_b) mem_b[addr_b[5:0]] <= bus_b;
    assign bus_a = (!ce_a && !oe_a && we_a) ? mem_a[addr_a[5:0]] : 16'hzzzz;
    assign bus_b = (!ce_b && !oe_b && we_b) ? mem_b[addr_b[5:0]] : 16'hzzzz;

    logic [31:0] rd_data_s;
    logic        rd_vld_s, busy_s, full_s, err_s;
    logic [3:0]  rec_cnt_s;
    logic [4:0]  strobes_s;
    logic [15:0] bus_s;
    logic [18:0] addr_s;
    assign rd_data_s = sel ? rd_data_b : rd_data_a;
    assign rd_vld_s  = sel ? rd_vld_b  : rd_vld_a;
    assign busy_s    = sel ? busy_b    : busy_a;
    assign full_s    = sel ? full_b    : full_a;
    assign err_s     = sel ? err_b     : err_a;
    assign rec_cnt_s = sel ? rec_cnt_b : rec_cnt_a;
    assign strobes_s = sel ? {we_b, oe_b, ce_b, ub_b, lb_b} : {we_a, oe_a, ce_a, ub_a, lb_a};
    assign bus_s     = sel ? bus_b     : bus_a;
    assign addr_s    = sel ? addr_b    : addr_a;

    int ce_low = 0;
    always @(negedge clk) if (!strobes_s[2]) ce_low <= ce_low + 1;

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] q [$];   // stored records, oldest first

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic reset_dut();
        clr = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
        @(negedge clk); @(negedge clk);
        clr = 1'b0;
        q.delete();
    endtask

    task automatic do_write(input logic [31:0] d, output int bcy, output int wcy);
        int n;
        wr_data = d; wr_req = 1'b1;
        @(negedge clk);
        wr_req = 1'b0; bcy = 0; wcy = 0; n = 0;
        while (busy_s && n < 40) begin
            bcy++;
            if (!strobes_s[4]) wcy++;
            n++;
            @(negedge clk);
        end
        if (n >= 40) chk("wr_timeout", busy_s, 0);
        if (!sel || q.size() < DEPTH) q.push_back(d);
        if (q.size() > DEPTH) q.delete(0);
    endtask

    task automatic do_read(input logic [2:0] idx, output int lat, output logic got_err);
        rd_idx = idx; rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0; lat = 1;
        while (!rd_vld_s && !err_s && lat < 40) begin
            lat++;
            @(negedge clk);
        end
        got_err = err_s;
        if (lat >= 40) chk("rd_timeout", rd_vld_s, 1);
        @(negedge clk);
    endtask

    initial begin
        int bcy, wcy, lat, errs, vlds, c0, idx;
        logic ge;
        logic [31:0] d;
        for (int i = 0; i < 64; i++) begin mem_a[i] = 16'h0; mem_b[i] = 16'h0; end
        sel = 1'b0; wr_data = '0; rd_idx = '0;
        reset_dut();

        chk("rst_busy", busy_s, 0);
        chk("rst_cnt", rec_cnt_s, 0);
        chk("rst_full", full_s, 0);
        chk("rst_err", err_s, 0);
        chk("rst_vld", rd_vld_s, 0);
        chk("rst_rd_data", rd_data_s, 0);
        chk("rst_strobes", strobes_s, 5'h1f);
        chk("rst_addr", addr_s, 0);
        chk("rst_bus_z", bus_s === 16'hzzzz, 1);

        do_write(32'h4162_0123, bcy, wcy);
        chk("wr_busy_cycles", bcy, 8);
        chk("wr_we_low_cycles", wcy, 4);
        chk("wr_mem0", mem_a[0], 16'h4162);
        chk("wr_mem1", mem_a[1], 16'h0123);
        chk("wr_cnt", rec_cnt_s, 1);

        do_read(3'd0, lat, ge);
        chk("rd_latency", lat, 7);
        chk("rd_data", rd_data_s, 32'h4162_0123);
        chk("rd_vld_pulse", rd_vld_s, 0);
        do_read(3'd1, lat, ge);
        chk("rd_range_err", ge, 1);
        chk("rd_held", rd_data_s, 32'h4162_0123);

        reset_dut();
        for (int i = 1; i <= 9; i++) do_write(32'(i), bcy, wcy);
        chk("wrap_full", full_s, 1);
        chk("wrap_cnt", rec_cnt_s, 8);
        chk("wrap_mem0", mem_a[0], 16'h0000);
        chk("wrap_mem1", mem_a[1], 16'h0009);
        do_read(3'd0, lat, ge);
        chk("wrap_idx0", rd_data_s, 32'd2);
        do_read(3'd7, lat, ge);
        chk("wrap_idx7", rd_data_s, 32'd9);

        reset_dut();
        for (int it = 0; it < 40; it++) begin
            if (q.size() == 0 || $urandom_range(0, 2) == 0) begin
                do_write($urandom, bcy, wcy);
                chk("rnd_cnt", rec_cnt_s, q.size());
            end else begin
                idx = $urandom_range(0, 7);
                do_read(3'(idx), lat, ge);
                if (idx < q.size()) begin
                    chk("rnd_rd_data", rd_data_s, q[idx]);
                    chk("rnd_rd_lat", lat, 7);
                end else begin
                    chk("rnd_rd_err", ge, 1);
                end
            end
        end

        wr_data = $urandom; wr_req = 1'b1;
        @(negedge clk);
        wr_req = 1'b0;
        @(negedge clk);
        chk("clr_in_pulse", strobes_s[4], 0);
        clr = 1'b1;
        @(negedge clk);
        chk("clr_strobes", strobes_s, 5'h1f);
        chk("clr_bus_z", bus_s === 16'hzzzz, 1);
        chk("clr_busy", busy_s, 0);
        chk("clr_cnt", rec_cnt_s, 0);
        clr = 1'b0;
        q.delete();

        wr_data = 32'hCAFE_0007; rd_idx = 3'd0; wr_req = 1'b1; rd_req = 1'b1;
        @(negedge clk);
        wr_req = 1'b0; rd_req = 1'b0; lat = 1; errs = 0;
        while (!rd_vld_s && lat < 40) begin
            rd_req = (lat == 3);
            if (err_s) errs++;
            lat++;
            @(negedge clk);
        end
        rd_req = 1'b0;
        q.push_back(32'hCAFE_0007);
        chk("sim_latency", lat, 15);
        chk("sim_rd_data", rd_data_s, q[0]);
        chk("sim_no_err", errs, 0);
        chk("sim_cnt", rec_cnt_s, 1);
        vlds = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rd_vld_s || err_s) vlds++;
        end
        chk("sim_dropped_rd", vlds, 0);

        sel = 1'b1;
        reset_dut();
        for (int i = 0; i < 8; i++) do_write($urandom, bcy, wcy);
        chk("nw_full", full_s, 1);
        c0 = ce_low;
        wr_data = 32'hDEAD_BEEF; wr_req = 1'b1;
        @(negedge clk);
        wr_req = 1'b0;
        chk("nw_full_err", err_s, 1);
        repeat (4) @(negedge clk);
        chk("nw_no_strobe", ce_low - c0, 0);
        chk("nw_cnt", rec_cnt_s, 8);
        do_read(3'd7, lat, ge);
        chk("nw_idx7", rd_data_s, q[7]);

        reset_dut();
        for (int i = 0; i < 3; i++) do_write($urandom, bcy, wcy);
        c0 = ce_low;
        do_read(3'd5, lat, ge);
        chk("nw_rd_err", ge, 1);
        chk("nw_rd_no_vld", lat, 1);
        chk("nw_rd_no_strobe", ce_low - c0, 0);
        do_read(3'd2, lat, ge);
        chk("nw_idx2", rd_data_s, q[2]);

        chk("addr_hi", {addr_a[18:6], addr_b[18:6]}, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
